// File: rtl/cpu_pkg.sv
// Shared decode encodings: opcodes, funct codes, op_type and FSM states.
package cpu_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_FPU   = 6'b010001;
    localparam logic [5:0] OP_IN    = 6'b011100;
    localparam logic [5:0] OP_OUT   = 6'b011101;
    localparam logic [5:0] OP_LUI_S = 6'b011111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW_S  = 6'b110001;
    localparam logic [5:0] OP_SW_S  = 6'b111001;

    localparam logic [5:0] FUNC_JR  = 6'b001000;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_OR  = 6'b100101;

    localparam logic [5:0] FPU_ADD  = 6'b000000;
    localparam logic [5:0] FPU_SUB  = 6'b000001;
    localparam logic [5:0] FPU_MUL  = 6'b000010;
    localparam logic [5:0] FPU_DIV  = 6'b000011;
    localparam logic [5:0] FPU_EQ   = 6'b010000;
    localparam logic [5:0] FPU_LT   = 6'b010001;
    localparam logic [5:0] FPU_LE   = 6'b010010;
    localparam logic [5:0] FPU_FTOI = 6'b010100;
    localparam logic [5:0] FPU_ITOF = 6'b010101;

    typedef logic [5:0] reg_addr_t;

    typedef enum logic [1:0] {
        OPT_I   = 2'd0,
        OPT_R   = 2'd1,
        OPT_FPU = 2'd2
    } op_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } dec_state_e;

    function automatic logic is_io(input logic [5:0] op);
        return (op == OP_IN) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Combined integer/float register file; address bit 5 selects the float bank.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h000F_FFFC,
    parameter logic [31:0] HP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  reg_addr_t   ra1,
    output logic [31:0] rd1,
    input  reg_addr_t   ra2,
    output logic [31:0] rd2,
    input  logic        we,
    input  reg_addr_t   wa,
    input  logic [31:0] wd
);

    logic [31:0] mem [64];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) begin
                mem[i[5:0]] <= (i == 29) ? SP_INIT :
                               (i == 30) ? HP_INIT : 32'h0;
            end
        end else if (we && wa != 6'd0) begin
            mem[wa] <= wd;
        end
    end

    // Integer r0 is hard-wired; float f0 (address 32) is ordinary.
    assign rd1 = (ra1 == 6'd0) ? 32'h0 : mem[ra1];
    assign rd2 = (ra2 == 6'd0) ? 32'h0 : mem[ra2];

endmodule

// File: rtl/decode_stage.sv
// Decode/register-read stage feeding execute; sequences IN/OUT start handshake.
// Define FORWARD_EN for same-cycle write-back bypass onto the source operands.
module decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h000F_FFFC,
    parameter logic [31:0] HP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_word,
    output logic [31:0] pc,
    output logic [5:0]  instr,
    output logic [1:0]  op_type,
    output logic [31:0] s,
    output logic [31:0] t,
    output logic [31:0] imm,
    output logic        branch,
    output logic        jump,
    output logic        is_jr,
    output logic        start,
    output reg_addr_t   dst,
    output logic        dst_en,
    output logic        out_valid,
    input  logic        uart_state,
    input  logic        wb_en,
    input  reg_addr_t   wb_addr,
    input  logic [31:0] wb_data
);

    dec_state_e state, state_n;
    logic load, start_n, drop;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic is_r, is_f, f_int_dst, f_itof;
    logic br_n, jmp_n, jr_n, den_n;
    logic [1:0] opt_n;
    logic [5:0] instr_n;
    logic [31:0] imm_n, s_n, rf_s, rf_t, s_val, t_val;
    reg_addr_t s_addr, t_addr, dst_n;

    assign op    = in_word[31:26];
    assign rs    = in_word[25:21];
    assign rt    = in_word[20:16];
    assign rd    = in_word[15:11];
    assign funct = in_word[5:0];

    always_comb begin
        is_r      = (op == OP_R);
        is_f      = (op == OP_FPU);
        f_itof    = is_f && (funct == FPU_ITOF);
        f_int_dst = is_f && (funct == FPU_EQ || funct == FPU_LT ||
                             funct == FPU_LE || funct == FPU_FTOI);
        br_n  = (op == OP_BEQ) || (op == OP_BNE) ||
                (op == OP_BGTZ) || (op == OP_BLEZ);
        jmp_n = (op == OP_J) || (op == OP_JAL);
        jr_n  = is_r && (funct == FUNC_JR);
        den_n = !(br_n || op == OP_J || jr_n || op == OP_SW ||
                  op == OP_SW_S || op == OP_OUT);

        opt_n   = is_r ? OPT_R : is_f ? OPT_FPU : OPT_I;
        instr_n = (is_r || is_f) ? funct : op;

        unique case (1'b1)
            jmp_n: imm_n = {6'b0, in_word[25:0]};
            (op == OP_ANDI || op == OP_ORI || op == OP_XORI):
                imm_n = {16'b0, in_word[15:0]};
            default: imm_n = {{16{in_word[15]}}, in_word[15:0]};
        endcase

        s_addr = {is_f && !f_itof, rs};
        t_addr = {(is_f && !f_itof) || op == OP_SW_S, rt};

        dst_n = (is_r || is_f) ? {1'b0, rd} :
                (op == OP_JAL) ? 6'd31 : {1'b0, rt};
        dst_n[5] = (is_f && !f_int_dst) || op == OP_LW_S || op == OP_LUI_S;
    end

    regfile_2r1w #(
        .SP_INIT (SP_INIT),
        .HP_INIT (HP_INIT)
    ) u_rf (
        .clk  (clk),
        .rstn (rstn),
        .ra1  (s_addr),
        .rd1  (rf_s),
        .ra2  (t_addr),
        .rd2  (rf_t),
        .we   (wb_en),
        .wa   (wb_addr),
        .wd   (wb_data)
    );

`ifdef FORWARD_EN
    assign s_val = (wb_en && wb_addr == s_addr && s_addr != 6'd0) ?
                   wb_data : rf_s;
    assign t_val = (wb_en && wb_addr == t_addr && t_addr != 6'd0) ?
                   wb_data : rf_t;
`else
    assign s_val = rf_s;
    assign t_val = rf_t;
`endif

    assign s_n = (op == OP_JAL) ? in_pc + 32'd4 : s_val;

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        start_n = 1'b0;
        drop    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (is_io(op)) begin
                        start_n = 1'b1;
                        state_n = S_ISSUE;
                    end
                end else begin
                    drop = 1'b1;
                end
            end
            S_ISSUE:     state_n = S_WAIT_BUSY;
            S_WAIT_BUSY: if (uart_state)  state_n = S_WAIT_DONE;
            S_WAIT_DONE: if (!uart_state) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            instr     <= '0;
            op_type   <= '0;
            s         <= '0;
            t         <= '0;
            imm       <= '0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            is_jr     <= 1'b0;
            start     <= 1'b0;
            dst       <= '0;
            dst_en    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            start <= start_n;
            if (load) begin
                pc        <= in_pc;
                instr     <= instr_n;
                op_type   <= opt_n;
                s         <= s_n;
                t         <= t_val;
                imm       <= imm_n;
                branch    <= br_n;
                jump      <= jmp_n;
                is_jr     <= jr_n;
                dst       <= dst_n;
                dst_en    <= den_n;
                out_valid <= 1'b1;
            end else if (drop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus IN/OUT and reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_word;
    logic [31:0] pc;
    logic [5:0]  instr;
    logic [1:0]  op_type;
    logic [31:0] s, t, imm;
    logic        branch, jump, is_jr, start;
    logic [5:0]  dst;
    logic        dst_en, out_valid;
    logic        uart_state, wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_word    (in_word),
        .pc         (pc),
        .instr      (instr),
        .op_type    (op_type),
        .s          (s),
        .t          (t),
        .imm        (imm),
        .branch     (branch),
        .jump       (jump),
        .is_jr      (is_jr),
        .start      (start),
        .dst        (dst),
        .dst_en     (dst_en),
        .out_valid  (out_valid),
        .uart_state (uart_state),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  op_type;
        logic [5:0]  instr;
        logic [31:0] imm;
        logic [31:0] s;
        logic [31:0] t;
        logic [5:0]  dst;
        logic        dst_en;
        logic        br;
        logic        jmp;
        logic        jr;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(negedge clk);
        wb_en    = 1'b0;
    endtask

    task automatic apply(input logic [31:0] w, input logic [31:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        in_pc    = p;
        @(posedge clk);
        #1;
    endtask

    int starts;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_word = '0;
        uart_state = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        vec[0]  = '{32'h03BE_0825, 32'h100, 2'd1, 6'h25, 32'h0000_0825,
                    32'h000F_FFFC, 32'h0, 6'h01, 1, 0, 0, 0};
        vec[1]  = '{32'h2108_FFFF, 32'h104, 2'd0, 6'h08, 32'hFFFF_FFFF,
                    32'h5, 32'h5, 6'h08, 1, 0, 0, 0};
        vec[2]  = '{32'h3409_8000, 32'h108, 2'd0, 6'h0D, 32'h0000_8000,
                    32'h0, 32'h99, 6'h09, 1, 0, 0, 0};
        vec[3]  = '{32'h0C00_0100, 32'h40, 2'd0, 6'h03, 32'h0000_0100,
                    32'h44, 32'h0, 6'h1F, 1, 0, 1, 0};
        vec[4]  = '{32'h4422_1811, 32'h10C, 2'd2, 6'h11, 32'h0000_1811,
                    32'h3F80_0000, 32'h4000_0000, 6'h03, 1, 0, 0, 0};
        vec[5]  = '{32'h4422_2000, 32'h110, 2'd2, 6'h00, 32'h0000_2000,
                    32'h3F80_0000, 32'h4000_0000, 6'h24, 1, 0, 0, 0};
        vec[6]  = '{32'h1109_FFFC, 32'h114, 2'd0, 6'h04, 32'hFFFF_FFFC,
                    32'h5, 32'h99, 6'h00, 0, 1, 0, 0};
        vec[7]  = '{32'h03E0_0008, 32'h118, 2'd1, 6'h08, 32'h0000_0008,
                    32'h0, 32'h0, 6'h00, 0, 0, 0, 1};
        vec[8]  = '{32'h0109_5020, 32'h11C, 2'd1, 6'h20, 32'h0000_5020,
                    32'h5, 32'h99, 6'h0A, 1, 0, 0, 0};
        vec[9]  = '{32'hE502_0004, 32'h120, 2'd0, 6'h39, 32'h0000_0004,
                    32'h5, 32'h4000_0000, 6'h00, 0, 0, 0, 0};
        vec[10] = '{32'h4500_2815, 32'h124, 2'd2, 6'h15, 32'h0000_2815,
                    32'h5, 32'h0, 6'h25, 1, 0, 0, 0};
        vec[11] = '{32'h7C06_3F80, 32'h128, 2'd0, 6'h1F, 32'h0000_3F80,
                    32'h0, 32'h0, 6'h26, 1, 0, 0, 0};
        vec[12] = '{32'h310B_FFFF, 32'h12C, 2'd0, 6'h0C, 32'h0000_FFFF,
                    32'h5, 32'h0, 6'h0B, 1, 0, 0, 0};
        vec[13] = '{32'h0BFF_FFFF, 32'h130, 2'd0, 6'h02, 32'h03FF_FFFF,
                    32'h0, 32'h0, 6'h00, 0, 0, 1, 0};
        vec[14] = '{32'h2001_0000, 32'h134, 2'd0, 6'h08, 32'h0000_0000,
                    32'h0, 32'h0, 6'h01, 1, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_dst", 32'({dst_en, dst}), 32'd0);
        chk("rst_flags", 32'({branch, jump, is_jr, op_type, instr}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset values of r29/r30 are read by vec[0] before any write.
        wb_write(6'd8, 32'h5);
        wb_write(6'd9, 32'h99);
        wb_write(6'h21, 32'h3F80_0000);
        wb_write(6'h22, 32'h4000_0000);
        wb_write(6'd0, 32'hDEAD_BEEF);

        for (int i = 0; i < 15; i++) begin
            apply(vec[i].word, vec[i].pc);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), pc, vec[i].pc);
            chk($sformatf("v%0d_optype", i), 32'(op_type), 32'(vec[i].op_type));
            chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vec[i].instr));
            chk($sformatf("v%0d_imm", i), imm, vec[i].imm);
            chk($sformatf("v%0d_s", i), s, vec[i].s);
            chk($sformatf("v%0d_t", i), t, vec[i].t);
            chk($sformatf("v%0d_dst_en", i), 32'(dst_en), 32'(vec[i].dst_en));
            if (vec[i].dst_en)
                chk($sformatf("v%0d_dst", i), 32'(dst), 32'(vec[i].dst));
            chk($sformatf("v%0d_ctl", i), 32'({branch, jump, is_jr}),
                32'({vec[i].br, vec[i].jmp, vec[i].jr}));
            chk($sformatf("v%0d_start", i), 32'(start), 32'd0);
        end

        // Idle cycle: valid drops, payload holds the last ADDI.
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_instr", 32'(instr), 32'h08);
        chk("idle_dst", 32'(dst), 32'h01);
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Same-cycle write-back of r5 against a read of r5.
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 6'd5; wb_data = 32'h1234;
        in_valid = 1'b1; in_word = 32'h20A5_0000; in_pc = 32'h200;
        @(posedge clk); #1;
`ifdef FORWARD_EN
        chk("byp_same", s, 32'h1234);
`else
        chk("byp_same", s, 32'h0);
`endif
        @(negedge clk);
        wb_en = 1'b0;
        @(posedge clk); #1;
        chk("byp_next", s, 32'h1234);

        // OUT r4 handshake.
        apply(32'h7480_0000, 32'h300);
        starts = int'(start);
        chk("out_start", 32'(start), 32'd1);
        chk("out_ready0", 32'(in_ready), 32'd0);
        chk("out_dst_en", 32'(dst_en), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        starts += int'(start);
        chk("out_issue_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        uart_state = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            starts += int'(start);
            chk($sformatf("out_busy%0d_ready", k), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        uart_state = 1'b0;
        @(posedge clk); #1;
        chk("out_done_ready", 32'(in_ready), 32'd1);
        chk("out_start_count", 32'(starts), 32'd1);

        // Reset abandons an IN/OUT wait and drops a concurrent write-back.
        wb_write(6'd29, 32'hABCD);
        apply(32'h7480_0000, 32'h304);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rstn = 1'b0;
        wb_en = 1'b1; wb_addr = 6'd7; wb_data = 32'h77;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wb_en = 1'b0;
        uart_state = 1'b1;
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) uart_state = 1'b0;
            @(posedge clk); #1;
            starts += int'(start);
            @(negedge clk);
        end
        chk("post_rst_start", 32'(starts), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        apply(32'h20E1_0000, 32'h400);
        chk("rst_wb_dropped", s, 32'd0);
        apply(32'h03BE_0825, 32'h404);
        chk("rst_sp_restored", s, 32'h000F_FFFC);
        @(negedge clk);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and register-read stage that sits directly upstream of `execute`. It accepts one fetched 32-bit instruction word per handshake and splits it into the `op_type`/`instr`/`imm` encoding that `execute` consumes. It reads operands from a 32-entry integer bank and a 32-entry float bank, and applies write-back results from the downstream stage. It also sequences the `start`/`uart_state` handshake for multi-cycle IN/OUT instructions.

## Interface
Parameters:
- SP_INIT, 32'h000F_FFFC, reset value of integer r29
- HP_INIT, 32'h0000_0000, reset value of integer r30

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- in_valid  in  1  fetch presents a word
- in_ready  out  1  stage accepts the word this cycle
- in_pc  in  32  PC of the word
- in_word  in  32  raw instruction
- pc  out  32  registered PC to execute
- instr  out  6  opcode (op_type 0) or funct (op_type 1/2)
- op_type  out  2  0 = I/J-type, 1 = integer R-type, 2 = FPU
- s, t  out  32  operand values
- imm  out  32  extended immediate or jump target
- branch, jump, is_jr  out  1  control-flow class
- start  out  1  one-cycle pulse for IN/OUT
- dst  out  6  destination register; bit 5 = float bank
- dst_en  out  1  instruction writes `dst`
- out_valid  out  1  outputs hold a live instruction
- uart_state  in  1  execute busy flag
- wb_en  in  1  write-back strobe
- wb_addr  in  6  write-back register; bit 5 = float
- wb_data  in  32  write-back value

## Operation
- **Field extraction.** op = word[31:26].
  - op 000000 gives op_type 1 and instr = funct.
  - op 010001 gives op_type 2 and instr = funct.
  - All other ops give op_type 0 and instr = op.
- **Immediate.** Sign-extended word[15:0] by default. Zero-extended for ANDI, ORI and XORI. J and JAL use zero-extended word[25:0].
- **Register banks.** Bank select is per source and per destination:
  - Integer R-type and I-type: all integer.
  - FPU: sources float; destination float, except EQ/LT/LE/FTOI, which write integer.
  - ITOF: source integer, destination float.
  - LW_S: destination float.
  - SW_S: `t` read from float.
  - LUI_S: destination float.
- **Destinations.**
  - R-type writes rd; I-type writes rt.
  - JAL writes r31, with `s` = in_pc + 4.
  - Branches, J, JR, SW, SW_S and OUT have dst_en = 0.
- **Control-flow flags.**
  - branch is set for BEQ, BNE, BGTZ and BLEZ.
  - jump is set for J and JAL.
  - is_jr is set for op_type 1 with funct JR.
- **Register zero.** Integer r0 always reads 0 and ignores writes. Float f0 is an ordinary register.
- **Write-back.** When wb_en is high, wb_data is written on the clock edge.
- **Control FSM.** States IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: in_ready = 1. An accepted non-IN/OUT word loads the outputs with out_valid = 1, and the FSM stays in IDLE.
  - IDLE, accepting IN/OUT: go to ISSUE, with start = 1 for that output cycle.
  - ISSUE: start returns to 0 and the outputs hold. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart_state = 1, then go to WAIT_DONE.
  - WAIT_DONE: wait for uart_state = 0, then return to IDLE.
  - in_ready = 0 in ISSUE, WAIT_BUSY and WAIT_DONE.
- **No input in IDLE.** With in_valid = 0, out_valid drops to 0 and the other outputs hold their last values.

## Timing
- Latency is one cycle: the word accepted at edge N appears on the outputs after edge N.
- Sustained throughput is one word per cycle, except IN/OUT, which occupies at least 4 cycles.
- Register-file reads are combinational from the banks; the outputs are registered.
- **Reset.** Asynchronous reset forces:
  - all outputs to 0, in_ready excepted: in_ready is a combinational decode of the FSM state, so it reads 1 (IDLE) throughout reset;
  - FSM to IDLE;
  - all registers to 0, except r29 = SP_INIT and r30 = HP_INIT.
- A reset asserted mid-IN/OUT abandons the wait. No start is re-issued.
- A write-back to the same register in the same cycle that the register is read is governed by FORWARD_EN.
- A write-back in the same cycle as a reset is dropped.

## Configuration
- **FORWARD_EN defined.** Write-through bypass. When wb_en is high and wb_addr matches a source register (same bank bit, same index, and not integer r0), that source receives wb_data in the same cycle.
- **FORWARD_EN undefined.** Sources read the pre-write register value. Software must separate dependent instructions by one slot.

## Structure
- Package `cpu_pkg` holds:
  - OP_*, FUNC_* and FPU_* localparams;
  - the op_type encoding;
  - the decode FSM state enum;
  - a 6-bit register address typedef.
- Sub-module `regfile_2r1w`: two read ports and one write port, 64 entries with bank bit as the address MSB, integer r0 forced to zero.
- `regfile_2r1w` is instantiated once. The bypass muxes live in `decode_stage`.

## Test plan
- **ADDI.** Word 0x2108_FFFF (ADDI r8, r8, -1) with r8 = 5 → next cycle op_type 0, instr 001000, imm 0xFFFF_FFFF, s 5, dst 0x08, dst_en 1.
- **ORI.** Word with imm 0x8000 → imm 0x0000_8000 (zero-extended).
- **JAL.** JAL 0x100 at pc 0x40 → jump 1, imm 0x100, s 0x44, dst 0x1F.
- **FLT bank select.** FLT with f1 = 0x3F80_0000 and f2 = 0x4000_0000 → op_type 2, s 0x3F80_0000, t 0x4000_0000, dst bank bit 0.
- **OUT handshake.** OUT r4 → start is high for exactly one cycle and in_ready stays 0. Then drive uart_state high for 3 cycles and low again → in_ready returns to 1 the cycle after uart_state falls.
- **Write-back bypass.** wb_en with r5 = 0x1234 in the same cycle as a read of r5 → s = 0x1234 with FORWARD_EN, old value without. A write to r0 → r0 still reads 0.
